// File: rtl/axi4l_ipif_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : axi4l_ipif_regbank
//  Brief    : Block-level register bank behind the AXI4-Lite IPIF. Provides
//             VERSION, SCRATCH, CTRL with soft-reset pulse, IRQ status/enable
//             with aggregated IRQ, and a 64-bit cycle counter with an atomic
//             hi-word snapshot. All accesses ack exactly one cycle after req.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4l_ipif_regbank #(
  parameter int          C_ADDR_WIDTH = 12,
  parameter int          C_DATA_WIDTH = 32,
  parameter int          C_NUM_IRQ    = 8,
  parameter logic [31:0] C_VERSION    = 32'h0001_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [C_ADDR_WIDTH-3:0] up_wr_addr,
  input  logic                    up_wr_req,
  input  logic [3:0]              up_wr_be,
  input  logic [C_DATA_WIDTH-1:0] up_wr_din,
  output logic                    up_wr_ack,
  input  logic [C_ADDR_WIDTH-3:0] up_rd_addr,
  input  logic                    up_rd_req,
  output logic [C_DATA_WIDTH-1:0] up_rd_dout,
  output logic                    up_rd_ack,
  input  logic [C_NUM_IRQ-1:0]    irq_src,
  output logic                    irq,
  output logic [C_DATA_WIDTH-1:0] ctrl,
  output logic                    soft_reset
);

  localparam int C_AW = C_ADDR_WIDTH - 2;

  localparam logic [C_AW-1:0] C_A_VERSION    = C_AW'(0);
  localparam logic [C_AW-1:0] C_A_SCRATCH    = C_AW'(1);
  localparam logic [C_AW-1:0] C_A_CTRL       = C_AW'(2);
  localparam logic [C_AW-1:0] C_A_IRQ_STATUS = C_AW'(3);
  localparam logic [C_AW-1:0] C_A_IRQ_ENABLE = C_AW'(4);
  localparam logic [C_AW-1:0] C_A_CNT_LO     = C_AW'(5);
  localparam logic [C_AW-1:0] C_A_CNT_HI     = C_AW'(6);

  // Interrupt registers are kept 32 bits wide; bits at and above C_NUM_IRQ
  // are held at constant zero by this mask.
  localparam logic [31:0] C_IRQ_MASK = 32'hFFFF_FFFF >> (32 - C_NUM_IRQ);

  generate
    if (C_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axi4l_ipif_regbank: C_DATA_WIDTH must be 32");
    end
    if (C_NUM_IRQ < 1 || C_NUM_IRQ > 32) begin : g_bad_num_irq
      $error("axi4l_ipif_regbank: C_NUM_IRQ must be in 1..32");
    end
  endgenerate

  logic [31:0]          scratch_q, scratch_d;
  logic [31:0]          ctrl_q, ctrl_d;
  logic [31:0]          irq_status_q, irq_status_d;
  logic [31:0]          irq_en_q, irq_en_d;
  logic [63:0]          cnt_q, cnt_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [C_NUM_IRQ-1:0] irq_src_q, irq_src_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 rd_ack_q, rd_ack_d;
  logic [31:0]          rd_dout_q, rd_dout_d;
  logic                 irq_q, irq_d;
  logic                 soft_reset_q, soft_reset_d;

  logic [31:0] wr_mask;
  logic [31:0] wr_bits;
  logic [31:0] irq_rise;
  logic [31:0] rd_mux;

  // Byte-lane mask, masked write data and rising-edge detect on IRQ sources.
  always_comb begin
    wr_mask  = {{8{up_wr_be[3]}}, {8{up_wr_be[2]}}, {8{up_wr_be[1]}}, {8{up_wr_be[0]}}};
    wr_bits  = up_wr_din & wr_mask;
    irq_rise = 32'(irq_src & ~irq_src_q);
  end

  // Read multiplexer; reflects register contents before any same-cycle write.
  always_comb begin
    rd_mux = 32'h0;
    case (up_rd_addr)
      C_A_VERSION:    rd_mux = C_VERSION;
      C_A_SCRATCH:    rd_mux = scratch_q;
      C_A_CTRL:       rd_mux = ctrl_q;
      C_A_IRQ_STATUS: rd_mux = irq_status_q;
      C_A_IRQ_ENABLE: rd_mux = irq_en_q;
      C_A_CNT_LO:     rd_mux = cnt_q[31:0];
      C_A_CNT_HI:     rd_mux = shadow_q;
      default:        rd_mux = 32'h0;
    endcase
  end

  // Next-state for registers, acks, counter, snapshot and IRQ aggregation.
  always_comb begin
    scratch_d    = scratch_q;
    ctrl_d       = ctrl_q;
    irq_en_d     = irq_en_q;
    soft_reset_d = 1'b0;
    shadow_d     = shadow_q;
    rd_dout_d    = rd_dout_q;
    wr_ack_d     = up_wr_req;
    rd_ack_d     = up_rd_req;
    cnt_d        = cnt_q + 64'd1;
    irq_src_d    = irq_src;
    irq_d        = |(irq_status_q & irq_en_q);
    // Set has priority over a simultaneous write-1-to-clear.
    irq_status_d = ((irq_status_q & ~((up_wr_req && up_wr_addr == C_A_IRQ_STATUS) ? wr_bits : 32'h0))
                    | irq_rise) & C_IRQ_MASK;

    if (up_wr_req) begin
      case (up_wr_addr)
        C_A_SCRATCH: scratch_d = (scratch_q & ~wr_mask) | wr_bits;
        C_A_CTRL: begin
          // Bit 0 is a self-clearing trigger and is never stored.
          ctrl_d       = ((ctrl_q & ~wr_mask) | wr_bits) & 32'hFFFF_FFFE;
          soft_reset_d = wr_bits[0];
        end
        C_A_IRQ_ENABLE: irq_en_d = ((irq_en_q & ~wr_mask) | wr_bits) & C_IRQ_MASK;
        default: ;
      endcase
    end

    if (up_rd_req) begin
      rd_dout_d = rd_mux;
      // Snapshot the upper counter word so a following CNT_HI read is coherent.
      if (up_rd_addr == C_A_CNT_LO) begin
        shadow_d = cnt_q[63:32];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scratch_q    <= 32'h0;
      ctrl_q       <= 32'h0;
      irq_status_q <= 32'h0;
      irq_en_q     <= 32'h0;
      cnt_q        <= 64'h0;
      shadow_q     <= 32'h0;
      irq_src_q    <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_dout_q    <= 32'h0;
      irq_q        <= 1'b0;
      soft_reset_q <= 1'b0;
    end else begin
      scratch_q    <= scratch_d;
      ctrl_q       <= ctrl_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      irq_src_q    <= irq_src_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      rd_dout_q    <= rd_dout_d;
      irq_q        <= irq_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign up_wr_ack  = wr_ack_q;
  assign up_rd_ack  = rd_ack_q;
  assign up_rd_dout = rd_dout_q;
  assign irq        = irq_q;
  assign ctrl       = ctrl_q;
  assign soft_reset = soft_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4l_ipif_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4l_ipif_regbank
//  Brief    : Directed self-checking bench for axi4l_ipif_regbank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4l_ipif_regbank;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [9:0]  up_wr_addr;
  logic        up_wr_req;
  logic [3:0]  up_wr_be;
  logic [31:0] up_wr_din;
  logic        up_wr_ack;
  logic [9:0]  up_rd_addr;
  logic        up_rd_req;
  logic [31:0] up_rd_dout;
  logic        up_rd_ack;
  logic [7:0]  irq_src;
  logic        irq;
  logic [31:0] ctrl;
  logic        soft_reset;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  axi4l_ipif_regbank #(
    .C_ADDR_WIDTH(12),
    .C_DATA_WIDTH(32),
    .C_NUM_IRQ   (8),
    .C_VERSION   (32'h0001_0000)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .up_wr_addr(up_wr_addr),
    .up_wr_req (up_wr_req),
    .up_wr_be  (up_wr_be),
    .up_wr_din (up_wr_din),
    .up_wr_ack (up_wr_ack),
    .up_rd_addr(up_rd_addr),
    .up_rd_req (up_rd_req),
    .up_rd_dout(up_rd_dout),
    .up_rd_ack (up_rd_ack),
    .irq_src   (irq_src),
    .irq       (irq),
    .ctrl      (ctrl),
    .soft_reset(soft_reset)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single write; returns at the negedge of the ack cycle.
  task automatic wr(input logic [9:0] addr, input logic [3:0] be, input logic [31:0] din);
    @(negedge aclk);
    up_wr_addr = addr; up_wr_be = be; up_wr_din = din; up_wr_req = 1'b1;
    @(negedge aclk);
    up_wr_req = 1'b0;
    check("wr_ack", {63'h0, up_wr_ack}, 64'h1);
  endtask

  // Single read with ack and data check; returns at the negedge of the ack cycle.
  task automatic rd(input logic [9:0] addr, input logic [31:0] exp, input string tag);
    @(negedge aclk);
    up_rd_addr = addr; up_rd_req = 1'b1;
    @(negedge aclk);
    up_rd_req = 1'b0;
    check({tag, "_ack"}, {63'h0, up_rd_ack}, 64'h1);
    check(tag, {32'h0, up_rd_dout}, {32'h0, exp});
  endtask

  initial begin
    aresetn = 1'b0; up_wr_addr = '0; up_wr_req = 1'b0; up_wr_be = '0; up_wr_din = '0;
    up_rd_addr = '0; up_rd_req = 1'b0; irq_src = '0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    // Reset state
    check("rst_outs", {58'h0, up_wr_ack, up_rd_ack, irq, soft_reset, 2'b00}, 64'h0);
    check("rst_dout", {32'h0, up_rd_dout}, 64'h0);
    check("rst_ctrl", {32'h0, ctrl}, 64'h0);

    // VERSION and SCRATCH after reset; ack must be a single-cycle pulse
    rd(10'h000, 32'h0001_0000, "version");
    @(negedge aclk);
    check("rd_ack_pulse", {63'h0, up_rd_ack}, 64'h0);
    rd(10'h001, 32'h0000_0000, "scratch_rst");

    // SCRATCH byte enables
    wr(10'h001, 4'b1111, 32'hDEAD_BEEF);
    @(negedge aclk);
    check("wr_ack_pulse", {63'h0, up_wr_ack}, 64'h0);
    wr(10'h001, 4'b0101, 32'h1234_5678);
    rd(10'h001, 32'hDE34_BE78, "scratch_be");

    // CTRL with soft reset pulse
    wr(10'h002, 4'b1111, 32'h0000_0031);
    check("soft_reset_hi", {63'h0, soft_reset}, 64'h1);
    check("ctrl_out", {32'h0, ctrl}, 64'h30);
    @(negedge aclk);
    check("soft_reset_lo", {63'h0, soft_reset}, 64'h0);
    rd(10'h002, 32'h0000_0030, "ctrl_rd");

    // IRQ set, aggregate, W1C clear
    wr(10'h004, 4'b1111, 32'h0000_0004);
    @(negedge aclk); irq_src = 8'h04;
    @(negedge aclk); irq_src = 8'h00;
    check("irq_n1", {63'h0, irq}, 64'h0);
    @(negedge aclk);
    check("irq_n2", {63'h0, irq}, 64'h1);
    rd(10'h003, 32'h0000_0004, "irq_status");
    wr(10'h003, 4'b1111, 32'h0000_0004);
    @(negedge aclk);
    check("irq_cleared", {63'h0, irq}, 64'h0);
    rd(10'h003, 32'h0000_0000, "irq_status_clr");

    // Set status again, then W1C coinciding with a new edge: set wins
    @(negedge aclk); irq_src = 8'h04;
    @(negedge aclk); irq_src = 8'h00;
    @(negedge aclk);
    up_wr_addr = 10'h003; up_wr_be = 4'b1111; up_wr_din = 32'h4; up_wr_req = 1'b1;
    irq_src = 8'h04;
    @(negedge aclk);
    up_wr_req = 1'b0; irq_src = 8'h00;
    check("w1c_set_ack", {63'h0, up_wr_ack}, 64'h1);
    rd(10'h003, 32'h0000_0004, "irq_set_wins");

    // Enable register only implements C_NUM_IRQ bits
    wr(10'h004, 4'b1111, 32'hFFFF_FFFF);
    rd(10'h004, 32'h0000_00FF, "irq_en_upper");

    // Counter snapshot with a forced counter value at the CNT_LO read
    @(negedge aclk);
    force dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    up_rd_addr = 10'h005; up_rd_req = 1'b1;
    @(posedge aclk);
    #1 release dut.cnt_q;
    @(negedge aclk);
    up_rd_req = 1'b0;
    check("cnt_lo_ack", {63'h0, up_rd_ack}, 64'h1);
    check("cnt_lo", {32'h0, up_rd_dout}, 64'hFFFF_FFFF);
    repeat (2) @(negedge aclk);
    rd(10'h006, 32'h0000_0001, "cnt_hi");

    // Same-cycle write and read of SCRATCH: read sees pre-write value
    @(negedge aclk);
    up_wr_addr = 10'h001; up_wr_be = 4'b1111; up_wr_din = 32'h55AA_55AA; up_wr_req = 1'b1;
    up_rd_addr = 10'h001; up_rd_req = 1'b1;
    @(negedge aclk);
    up_wr_req = 1'b0; up_rd_req = 1'b0;
    check("rw_acks", {62'h0, up_wr_ack, up_rd_ack}, 64'h3);
    check("rw_old", {32'h0, up_rd_dout}, 64'hDE34_BE78);
    rd(10'h001, 32'h55AA_55AA, "rw_new");

    // Writes to read-only VERSION are ignored
    wr(10'h000, 4'b1111, 32'hFFFF_FFFF);
    rd(10'h000, 32'h0001_0000, "version_ro");

    // Reset asserted while a read is pending cancels the ack
    @(negedge aclk);
    up_rd_addr = 10'h000; up_rd_req = 1'b1;
    #2 aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("rst_mid_ack", {63'h0, up_rd_ack}, 64'h0);
    @(negedge aclk);
    up_rd_req = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_mid_outs", {60'h0, up_wr_ack, up_rd_ack, irq, soft_reset}, 64'h0);
    check("rst_mid_dout", {32'h0, up_rd_dout}, 64'h0);
    check("rst_mid_ctrl", {32'h0, ctrl}, 64'h0);
    rd(10'h3FF, 32'h0000_0000, "unmapped");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
